instr_fetch_unit: RTL and testbench

Instruction fetch stage of the 19-bit core. It sits directly upstream of the decode/control stage. It generates sequential instruction addresses, issues them to the instruction memory port, and buffers returned words in a small prefetch FIFO. Decode consumes words over a valid/ready handshake. A redirect from execute (JMP) flushes the FIFO and discards in-flight fetches.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 41 ++++
 rtl/instr_fetch_unit.sv | 88 ++++++++
 tb/tb_instr_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and payload types for the instruction fetch stage.
package fetch_pkg;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 19;
  localparam int unsigned OPC_HI = 18;
  localparam int unsigned OPC_LO = 15;
  localparam logic [3:0]  OP_JMP = 4'b1111;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] word;
  } fetch_entry_t;

  function automatic logic [3:0] opcode_of(input logic [DATA_W-1:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

  function automatic logic is_jmp(input logic [DATA_W-1:0] word);
    return opcode_of(word) == OP_JMP;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, word} entries with a synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         valid,
  output logic [CW-1:0] count
);
  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointers wrap naturally at the power-of-two depth; count tells full from empty.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign valid = (count != '0);
  assign head  = valid ? mem[rd_ptr] : '0;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: credit-limited sequential requests, in-order response tracking, redirect flush.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] ret_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_next;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     count;
  logic [CW:0]       credit_used;
  logic              grant;
  logic              resp;
  logic              push;
  logic              pop;
  fetch_entry_t      push_data;
  fetch_entry_t      head;

  // Occupancy plus in-flight requests never exceeds DEPTH, so the FIFO cannot overflow.
  always_comb begin
    credit_used      = (CW+1)'(count) + (CW+1)'(outstanding);
    mem_req          = !reset && !redirect && (credit_used < (CW+1)'(DEPTH));
    grant            = mem_req && mem_gnt;
    resp             = mem_rvalid && (outstanding != '0);
    push             = resp && (discard == '0) && !redirect;
    pop              = instr_valid && instr_ready && !redirect;
    outstanding_next = outstanding + CW'(grant) - CW'(resp);
    push_data        = '{pc: ret_pc, word: mem_rdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      ret_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect) begin
        // Every response still owed after this cycle belongs to the old stream.
        fetch_pc <= redirect_pc;
        ret_pc   <= redirect_pc;
        discard  <= outstanding_next;
      end else begin
        if (grant) fetch_pc <= fetch_pc + ADDR_W'(1);
        if (resp) begin
          if (discard != '0) discard <= discard - CW'(1);
          else               ret_pc  <= ret_pc + ADDR_W'(1);
        end
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .valid     (instr_valid),
    .count     (count)
  );

  assign mem_addr = fetch_pc;
  assign instr    = head.word;
  assign instr_pc = head.pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with an in-order variable-latency memory model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } pend_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC('0)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  int                n_checks = 0;
  int                n_pass   = 0;
  int                cyc      = 0;
  int                lat      = 1;
  int                ngrants  = 0;
  fetch_entry_t      sb[$];
  pend_t             pend[$];
  logic [ADDR_W-1:0] pop_pcs[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return a ^ 19'h2A5C3;
  endfunction

  // One cycle: drive inputs at negedge, then observe, score pops and record grants.
  task automatic step(input logic rs, input logic rd, input logic [ADDR_W-1:0] rpc,
                      input logic rdy, input logic gnt);
    fetch_entry_t e;
    pend_t        p;
    @(negedge clk);
    reset       = rs;
    redirect    = rd;
    redirect_pc = rpc;
    instr_ready = rdy;
    mem_gnt     = gnt;
    if (rs) begin
      pend.delete();
      sb.delete();
    end
    if (!rs && pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = word_of(pend[0].addr);
      pend.delete(0);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    #1;
    if (!rs) begin
      if (rd) begin
        check("redirect_no_req", mem_req, 0);
        sb.delete();
      end else begin
        if (instr_valid && instr_ready) begin
          if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
          else begin
            e = sb[0];
            sb.delete(0);
            check("instr_pc", instr_pc, e.pc);
            check("instr", instr, e.word);
            pop_pcs.push_back(instr_pc);
          end
        end
        if (mem_req && mem_gnt) begin
          e.pc   = mem_addr;
          e.word = word_of(mem_addr);
          sb.push_back(e);
          p.addr = mem_addr;
          p.due  = cyc + lat;
          pend.push_back(p);
          ngrants++;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    repeat (2) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    pop_pcs.delete();
  endtask

  initial begin
    int first;
    int mark;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; instr_ready = 1'b0;

    // Reset values
    lat = 1;
    repeat (3) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);

    // Streaming with single-cycle memory
    pop_pcs.delete();
    first = -1;
    mark  = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      if (first < 0 && instr_valid) first = i;
      if (i == 9) mark = pop_pcs.size();
    end
    check("first_valid_cycle", first, 2);
    check("stream_throughput", pop_pcs.size() - mark, 10);
    check("stream_pc0", pop_pcs[0], 0);
    check("stream_pc3", pop_pcs[3], 3);

    // Backpressure: exactly DEPTH grants, then drain in order
    do_reset();
    ngrants = 0;
    repeat (10) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("bp_grants", ngrants, 4);
    check("bp_req_low", mem_req, 0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("bp_resume_req", mem_req, 1);
    check("bp_resume_addr", mem_addr, 4);
    repeat (10) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("bp_drain0", pop_pcs[0], 0);
    check("bp_drain3", pop_pcs[3], 3);

    // Redirect with three fetches in flight
    lat = 3;
    do_reset();
    repeat (3) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 19'h00100, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("rd_valid_after", instr_valid, 0);
    check("rd_req_after", mem_req, 1);
    check("rd_addr_after", mem_addr, 19'h00100);
    repeat (15) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("rd_first_pc", pop_pcs[0], 19'h00100);
    check("rd_second_pc", pop_pcs[1], 19'h00101);

    // Redirect, pop and rvalid in the same cycle
    lat = 1;
    do_reset();
    repeat (8) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 19'h00200, 1'b1, 1'b1);
    check("simul_valid_in_redirect", instr_valid, 1);
    pop_pcs.delete();
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("simul_empty_after", instr_valid, 0);
    repeat (10) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("simul_first_pc", pop_pcs[0], 19'h00200);

    // Address wrap
    step(1'b0, 1'b1, 19'h7FFFE, 1'b1, 1'b1);
    pop_pcs.delete();
    repeat (10) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("wrap_pc0", pop_pcs[0], 19'h7FFFE);
    check("wrap_pc1", pop_pcs[1], 19'h7FFFF);
    check("wrap_pc2", pop_pcs[2], 19'h00000);

    // Reset mid-operation with 2 entries buffered and 1 fetch outstanding
    lat = 2;
    do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("mid_pre_valid", instr_valid, 1);
    pop_pcs.delete();
    mark = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      if (i == 0) begin
        check("mid_valid_cleared", instr_valid, 0);
        check("mid_req", mem_req, 1);
        check("mid_addr", mem_addr, 0);
      end
      if (i == 5) mark = pop_pcs.size();
    end
    check("mid_pc0", pop_pcs[0], 0);
    check("mid_pc1", pop_pcs[1], 1);
    check("mid_throughput", pop_pcs.size() - mark, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
